// File: rtl/seg_pkg.sv
// Shared digit/display definitions: BCD digit type, segment patterns,
// converter FSM states and the multiply-by-10 accumulate step.
package seg_pkg;

  typedef logic [3:0] bcd_t;

  typedef enum logic [1:0] {
    IDLE,
    CONV,
    DONE
  } state_t;

  // Width of the shift-add helper; callers truncate to their own result width (<= 32).
  localparam int MUL_W = 32;

  // Segment patterns {g,f,e,d,c,b,a}, active high; codes 10..15 are blank.
  localparam logic [15:0][6:0] SEG_LOOKUP = {
    7'h00, 7'h00, 7'h00, 7'h00, 7'h00, 7'h00,
    7'h6F, 7'h7F, 7'h07, 7'h7D, 7'h6D, 7'h66, 7'h4F, 7'h5B, 7'h06, 7'h3F
  };

  function automatic logic [MUL_W-1:0] mul10_add(input logic [MUL_W-1:0] acc,
                                                 input bcd_t digit);
    return (acc << 3) + (acc << 1) + MUL_W'(digit);
  endfunction

endpackage

// File: rtl/bcd_to_bin.sv
// Sequential packed-BCD to unsigned binary converter, one digit per clock,
// with valid/ready handshakes on input and output.
module bcd_to_bin
  import seg_pkg::*;
#(
  parameter int DIGITS = 4,
  parameter int OUT_W  = 14
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DIGITS*4-1:0]   in_digits,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [OUT_W-1:0]      out_value,
  output logic                  out_err
);

  localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DIGITS - 1);

  state_t               state_q, state_d;
  logic [DIGITS*4-1:0]  digits_q, digits_d;
  logic [OUT_W-1:0]     acc_q, acc_d;
  logic [IDX_W-1:0]     idx_q, idx_d;
  logic                 err_q, err_d;
  bcd_t                 cur_digit;

  // Latched digits are shifted left each step, so the digit at idx is always the top nibble.
  assign cur_digit = digits_q[DIGITS*4-1 -: 4];

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      digits_q <= '0;
      acc_q    <= '0;
      idx_q    <= '0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      digits_q <= digits_d;
      acc_q    <= acc_d;
      idx_q    <= idx_d;
      err_q    <= err_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    digits_d = digits_q;
    acc_d    = acc_q;
    idx_d    = idx_q;
    err_d    = err_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          digits_d = in_digits;
          acc_d    = '0;
          idx_d    = '0;
          err_d    = 1'b0;
          state_d  = CONV;
        end
      end
      CONV: begin
        acc_d    = OUT_W'(mul10_add(MUL_W'(acc_q), cur_digit));
        digits_d = digits_q << 4;
        idx_d    = idx_q + 1'b1;
        if (cur_digit > 4'd9) begin
          err_d = 1'b1;
        end
        if (idx_q == LAST_IDX) begin
          state_d = DONE;
        end
      end
      DONE: begin
        if (out_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Outputs depend only on registered state, so no in_* or out_ready path reaches them.
  always_comb begin
    in_ready  = (state_q == IDLE);
    out_valid = (state_q == DONE);
    out_value = '0;
    out_err   = 1'b0;
    if (state_q == DONE) begin
      out_value = err_q ? '0 : acc_q;
      out_err   = err_q;
    end
  end

endmodule

// File: tb/tb_bcd_to_bin.sv
// Self-checking bench for bcd_to_bin: directed table, handshake corner
// sequences and randomized back-to-back traffic against a decimal model.
module tb_bcd_to_bin;

  localparam int DIGITS = 4;
  localparam int OUT_W  = 14;

  logic                 clk = 1'b0;
  logic                 rst = 1'b1;
  logic                 in_valid = 1'b0;
  logic                 in_ready;
  logic [DIGITS*4-1:0]  in_digits = '0;
  logic                 out_valid;
  logic                 out_ready = 1'b1;
  logic [OUT_W-1:0]     out_value;
  logic                 out_err;

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;
  bit mon_en = 1'b0;
  int n_out = 0;
  int exp_q[$];

  always #5 clk = ~clk;

  bcd_to_bin #(.DIGITS(DIGITS), .OUT_W(OUT_W)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_digits (in_digits),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_value (out_value),
    .out_err   (out_err)
  );

  typedef struct {
    string       name;
    logic [15:0] digits;
    int          exp_value;
    bit          exp_err;
  } vec_t;

  task automatic chk(input string name, input longint act, input longint exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  // Decimal value of the packed digits, most significant first; 0 if any digit > 9.
  function automatic void ref_conv(input logic [15:0] d, output int val, output bit err);
    int nib;
    val = 0;
    err = 1'b0;
    for (int k = 0; k < DIGITS; k++) begin
      nib = int'((d >> (4 * (DIGITS - 1 - k))) & 16'h000F);
      if (nib > 9) err = 1'b1;
      val = val * 10 + nib;
    end
    if (err) val = 0;
  endfunction

  function automatic logic [15:0] rand_valid();
    logic [15:0] d = '0;
    for (int k = 0; k < DIGITS; k++) d = (d << 4) | 16'($urandom_range(9));
    return d;
  endfunction

  task automatic accept(input logic [15:0] d);
    int w = 0;
    while (!in_ready && w < 20) begin
      step();
      w++;
    end
    if (!in_ready) chk("accept_timeout", 0, 1);
    in_digits = d;
    in_valid  = 1'b1;
    step();
    in_valid  = 1'b0;
    in_digits = 16'($urandom);
  endtask

  task automatic await_out(output int lat);
    lat = 1;
    while (!out_valid && lat < 40) begin
      step();
      lat++;
    end
  endtask

  task automatic convert(input string name, input logic [15:0] d, input int exp_v, input bit exp_e);
    int lat;
    accept(d);
    await_out(lat);
    $display("%s: digits=%h value=%0d err=%0d latency=%0d", name, d, out_value, out_err, lat);
    chk({name, "_latency"}, lat, DIGITS + 1);
    chk({name, "_value"}, out_value, exp_v);
    chk({name, "_err"}, out_err, exp_e);
    chk({name, "_in_ready_busy"}, in_ready, 0);
    step();
    chk({name, "_out_valid_drop"}, out_valid, 0);
    chk({name, "_in_ready_back"}, in_ready, 1);
  endtask

  always @(negedge clk) begin
    if (mon_en && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        chk("b2b_extra_output", out_value, -1);
      end else begin
        chk("b2b_value", out_value, exp_q.pop_front());
        chk("b2b_err", out_err, 0);
      end
      n_out++;
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t tbl[7];
    int   lat, rv, last, bad;
    bit   re;
    logic [15:0] d;

    tbl[0] = '{"basic_1234",   16'h1234, 1234, 1'b0};
    tbl[1] = '{"max_9999",     16'h9999, 9999, 1'b0};
    tbl[2] = '{"zero",         16'h0000, 0,    1'b0};
    tbl[3] = '{"seven",        16'h0007, 7,    1'b0};
    tbl[4] = '{"thousand",     16'h1000, 1000, 1'b0};
    tbl[5] = '{"invalid_1A34", 16'h1A34, 0,    1'b1};
    tbl[6] = '{"after_err_42", 16'h0042, 42,   1'b0};

    // Reset state
    repeat (3) step();
    rst = 1'b0;
    chk("reset_in_ready", in_ready, 1);
    chk("reset_out_valid", out_valid, 0);
    chk("reset_out_value", out_value, 0);
    chk("reset_out_err", out_err, 0);
    step();

    foreach (tbl[i]) convert(tbl[i].name, tbl[i].digits, tbl[i].exp_value, tbl[i].exp_err);

    // Backpressure with in_valid pulsing during the stall
    out_ready = 1'b0;
    accept(16'h4321);
    await_out(lat);
    chk("bp_latency", lat, DIGITS + 1);
    bad = 0;
    for (int i = 0; i < 10; i++) begin
      if (!out_valid || in_ready || out_value != 14'd4321 || out_err) bad++;
      in_valid  = i[0];
      in_digits = 16'h5555;
      step();
    end
    in_valid = 1'b0;
    $display("backpressure: held value=%0d over 10 stalled cycles, bad cycles=%0d", out_value, bad);
    chk("bp_held_stable", bad, 0);
    chk("bp_value_end", out_value, 4321);
    out_ready = 1'b1;
    step();
    chk("bp_released", out_valid, 0);
    convert("bp_next_5555", 16'h5555, 5555, 1'b0);

    // Reset during the second CONV cycle
    accept(16'h9876);
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("midrst_in_ready", in_ready, 1);
    chk("midrst_out_valid", out_valid, 0);
    bad = 0;
    for (int i = 0; i < 8; i++) begin
      if (out_valid) bad++;
      step();
    end
    $display("mid_reset: spurious output cycles=%0d", bad);
    chk("midrst_no_output", bad, 0);
    convert("after_rst_5678", 16'h5678, 5678, 1'b0);

    // Random digits including invalid codes
    for (int i = 0; i < 20; i++) begin
      d = 16'($urandom);
      ref_conv(d, rv, re);
      convert("rand_any", d, rv, re);
    end

    // Back-to-back random valid vectors, out_ready tied high
    mon_en = 1'b1;
    n_out  = 0;
    last   = 0;
    for (int i = 0; i < 100; i++) begin
      d = rand_valid();
      in_digits = d;
      in_valid  = 1'b1;
      bad = 0;
      while (!in_ready && bad < 20) begin
        step();
        bad++;
      end
      if (i > 0) chk("b2b_spacing", cyc - last, DIGITS + 2);
      last = cyc;
      ref_conv(d, rv, re);
      exp_q.push_back(rv);
      $display("b2b %0d: digits=%h expect=%0d at cycle %0d", i, d, rv, cyc);
      step();
    end
    in_valid = 1'b0;
    repeat (12) step();
    mon_en = 1'b0;
    chk("b2b_output_count", n_out, 100);
    chk("b2b_queue_empty", exp_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
